// File: rtl/inst_sram_rsp_pkg.sv
// Shared constants and helpers for the instruction SRAM responder.
package inst_sram_rsp_pkg;

    localparam int unsigned XLEN        = 32;
    localparam logic [2:0]  SEG_KSEG0   = 3'b100;
    localparam logic [2:0]  SEG_KSEG1   = 3'b101;
    localparam logic [31:0] RESET_PBASE = 32'h1fc00000;

    // Kind of access presented on the bus this cycle.
    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_e;

    // kseg0 and kseg1 are the only directly translated segments.
    function automatic logic seg_mapped(input logic [2:0] seg);
        return (seg == SEG_KSEG0) || (seg == SEG_KSEG1);
    endfunction

endpackage

// File: rtl/inst_sram_rsp_if.sv
// Instruction SRAM bus: request from the fetch stage, response from the SRAM.
interface inst_sram_rsp_if #(
    parameter int unsigned DW = 32
);
    logic          inst_sram_en;
    logic [3:0]    inst_sram_wen;
    logic [DW-1:0] inst_sram_addr;
    logic [DW-1:0] inst_sram_wdata;
    logic [DW-1:0] inst_sram_rdata;
    logic          inst_sram_rvalid;
    logic          inst_sram_err;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata, inst_sram_rvalid, inst_sram_err
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata, inst_sram_rvalid, inst_sram_err
    );
endinterface

// File: rtl/inst_sram_rsp_sram_bytewr_1p.sv
// Single-port word array with per-byte write enables and a registered read.
// Contents are never reset.
module sram_bytewr_1p #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          i_rd,
    input  logic          i_wr,
    input  logic [3:0]    i_wen,
    input  logic [AW-1:0] i_idx,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_q;

    // Byte-masked write into the addressed word.
    always_ff @(posedge clk) begin
        if (i_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (i_wen[b]) begin
                    r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register only updates on a read, so it holds across idle/write cycles.
    always_ff @(posedge clk) begin
        if (i_rd) begin
            r_q <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/inst_sram_rsp.sv
// Instruction SRAM responder: kseg0/kseg1 translation, window check,
// one-cycle read response and a sticky first-error capture.
module inst_sram_rsp
    import inst_sram_rsp_pkg::*;
#(
    parameter int unsigned   DW         = XLEN,
    parameter int unsigned   DEPTH_LOG2 = 12,
    parameter logic [DW-1:0] PBASE      = RESET_PBASE
) (
    input  logic                clk,
    input  logic                resetn,
    inst_sram_rsp_if.slave      inst_sram,
    input  logic                err_clr,
    output logic [DW-1:0]       err_addr
);

    localparam logic [DW:0] WIN_BYTES = (DW+1)'(1) << (DEPTH_LOG2 + 2);

    acc_e                  w_kind;
    logic [DW-1:0]         w_phys;
    logic [DW-1:0]         w_off;
    logic                  w_mapped;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_sram_rd;
    logic                  w_sram_wr;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [DW-1:0]         w_q;

    logic                  r_rvalid;
    logic                  r_rd_hit;
    logic                  r_err;
    logic [DW-1:0]         r_err_addr;

    // Classify the request and decide hit/miss.
    always_comb begin
        w_kind = ACC_IDLE;
        if (inst_sram.inst_sram_en) begin
            w_kind = (inst_sram.inst_sram_wen == 4'h0) ? ACC_READ : ACC_WRITE;
        end
        w_mapped      = seg_mapped(inst_sram.inst_sram_addr[31:29]);
        w_phys        = inst_sram.inst_sram_addr;
        w_phys[31:29] = 3'b000;
        w_off         = w_phys - PBASE;
        w_hit         = w_mapped
                        && (inst_sram.inst_sram_addr[1:0] == 2'b00)
                        && (w_phys >= PBASE)
                        && ({1'b0, w_off} < WIN_BYTES);
        w_miss        = (w_kind != ACC_IDLE) && !w_hit;
        w_sram_rd     = (w_kind == ACC_READ) && w_hit;
        w_sram_wr     = (w_kind == ACC_WRITE) && w_hit;
        w_idx         = w_off[DEPTH_LOG2+1:2];
    end

    sram_bytewr_1p #(
        .AW (DEPTH_LOG2),
        .DW (DW)
    ) u_sram (
        .clk     (clk),
        .i_rd    (w_sram_rd),
        .i_wr    (w_sram_wr),
        .i_wen   (inst_sram.inst_sram_wen),
        .i_idx   (w_idx),
        .i_wdata (inst_sram.inst_sram_wdata),
        .o_rdata (w_q)
    );

    // Response flags: rvalid pulses after any read; r_rd_hit selects array data or zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rvalid <= 1'b0;
            r_rd_hit <= 1'b0;
        end else begin
            r_rvalid <= (w_kind == ACC_READ);
            if (w_kind == ACC_READ) begin
                r_rd_hit <= w_hit;
            end
        end
    end

    // Sticky error; a miss alongside err_clr still sets it and recaptures the address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_miss) begin
            r_err <= 1'b1;
            if (!r_err || err_clr) begin
                r_err_addr <= inst_sram.inst_sram_addr;
            end
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign inst_sram.inst_sram_rdata  = r_rd_hit ? w_q : '0;
    assign inst_sram.inst_sram_rvalid = r_rvalid;
    assign inst_sram.inst_sram_err    = r_err;
    assign err_addr                   = r_err_addr;

endmodule

// File: doc/inst_sram_rsp.md
INST_SRAM_RSP -- requirements
Module: inst_sram_rsp

Interface
REQ-001 SHALL have parameter DW, default 32 (`XLEN), data and address width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, giving a word array of 2^DEPTH_LOG2 entries (16 KiB).
REQ-003 SHALL have parameter PBASE, default 32'h1fc00000, the physical byte base of the array.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port inst_sram_en, input, 1: access request this cycle.
REQ-007 SHALL have port inst_sram_wen, input, 4: byte write enables; 0 means read.
REQ-008 SHALL have port inst_sram_addr, input, DW: virtual byte address.
REQ-009 SHALL have port inst_sram_wdata, input, DW: write data.
REQ-010 SHALL have port inst_sram_rdata, output, DW: read data.
REQ-011 SHALL have port inst_sram_rvalid, output, 1: rdata corresponds to the previous cycle's read.
REQ-012 SHALL have port inst_sram_err, output, 1: sticky access-error flag.
REQ-013 SHALL have port err_clr, input, 1: synchronous clear of inst_sram_err.
REQ-014 SHALL have port err_addr, output, DW: virtual address of the first error since the last clear.

Function
REQ-015 SHALL translate addresses: kseg0 (addr[31:29]=3'b100) and kseg1 (3'b101) map to {3'b000, addr[28:0]}; all other segments are unmapped.
REQ-016 SHALL treat an access as a hit when it is mapped, addr[1:0]=2'b00, and the physical address lies in [PBASE, PBASE + 4*2^DEPTH_LOG2).
REQ-017 SHALL use word index (phys - PBASE) >> 2, truncated to DEPTH_LOG2 bits.
REQ-018 On a hit read (en=1, wen=0), SHALL drive rdata with the array word exactly one cycle later and pulse rvalid for that cycle.
REQ-019 On a hit write (en=1, wen!=0), SHALL update only the bytes whose wen bit is set, at the clock edge; a write SHALL NOT assert rvalid or change rdata.
REQ-020 A read following a write to the same word in the next cycle SHALL return the written data.
REQ-021 SHALL hold rdata stable while en=0, or during writes, until the next completed read.
REQ-022 A miss read (unmapped, misaligned or out of window) SHALL return rdata=0 with rvalid=1 one cycle later.
REQ-023 Any miss access (read or write) SHALL set inst_sram_err at the edge; a miss write SHALL leave the array unchanged.
REQ-024 SHALL capture err_addr only when inst_sram_err is currently 0, so the first error wins.
REQ-025 err_clr SHALL clear inst_sram_err on the next edge; a miss in the same cycle as err_clr SHALL win: err stays 1 and err_addr is recaptured.
REQ-026 SHALL operate back-to-back with one access per cycle and no stall; the fixed latency matches a fetch stage that presents next_pc in the cycle before it latches it.
REQ-027 SHALL accept inputs with en=0 without any side effect.

Reset
REQ-028 While resetn=0, SHALL force rdata=0, rvalid=0, inst_sram_err=0 and err_addr=0.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 If reset asserts in the cycle after a read, SHALL suppress rvalid; the read is lost.
REQ-031 SHALL accept the first request on the first rising edge after resetn deasserts.

Structure
REQ-032 SHALL take `XLEN and the segment/PBASE constants from the shared cpu.vh header.
REQ-033 SHALL build the rdata/rvalid/err/err_addr registers from the codebase's generic async-reset DFF cells.
REQ-034 SHALL place the array and byte-write logic in one sub-module, sram_bytewr_1p (single port, registered read).

Verification
REQ-035 Reset-vector fetch: after reset, read 0xbfc00000 holding 0x3c1d8000 -> next cycle rdata=0x3c1d8000, rvalid=1, err=0.
REQ-036 Byte write: write 0x11223344 (wen=4'hf), then wen=4'b0010 with data 0xAABBCCDD at 0x9fc00010, then read -> 0x1122CC44.
REQ-037 Write-then-read: back-to-back write/read of 0xbfc00020 -> rdata equals the new data.
REQ-038 Errors: read 0xbfc00002 -> rdata=0, rvalid=1, err=1, err_addr=0xbfc00002; then read 0x00001000 -> err_addr unchanged; err_clr together with a miss at 0xc0000000 -> err=1, err_addr=0xc0000000.
REQ-039 Window edge: read 0xbfc03ffc -> hit; read 0xbfc04000 -> miss with err set.
REQ-040 Reset mid-read: drop resetn the cycle after a read -> rvalid=0, rdata=0; array word still readable afterwards.
